echo_line_reader: RTL and testbench
===================================

# echo_line_reader

Consumer-side companion to the per-channel echo sample FIFO. It drains samples from the FIFO's combinational read port and re-frames them into scan lines of `LINE_LEN` samples on a valid/ready stream toward the beamformer summation stage. A start pulse arms a capture of `num_lines` lines. The block reports busy/done status and a FIFO-starvation stall count for the sequencer.

## Interface
- `DATA_WIDTH`, 16, sample width; matches FIFO `data_out`.
- `ADDR_WIDTH`, 3, FIFO address width; FIFO occupancy is `ADDR_WIDTH+1` bits.
- `LINE_LEN`, 64, samples per scan line; must be at least 2. Counter width is `$clog2(LINE_LEN)`.
- `clk`  in  1  single clock; all logic rises on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  one-cycle arm pulse; sampled only in IDLE.
- `num_lines`  in  16  lines to transfer; latched on accepted `start`.
- `fifo_data`  in  DATA_WIDTH  FIFO head sample; valid in the same cycle whenever `fifo_count != 0`.
- `fifo_count`  in  ADDR_WIDTH+1  FIFO occupancy.
- `fifo_rd_en`  out  1  pop strobe; FIFO advances its read pointer on this edge.
- `m_data`  out  DATA_WIDTH  output sample (registered).
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_first`  out  1  beat is sample 0 of a line.
- `m_last`  out  1  beat is sample `LINE_LEN-1` of a line.
- `busy`  out  1  high from the cycle after an accepted `start` until completion.
- `done`  out  1  one-cycle completion pulse.
- `stall_count`  out  16  starvation cycles, saturating.

## Operation
- States are IDLE, STREAM, and FINISH.
- **IDLE:**
  - `start`=1 with `num_lines`≠0 latches `num_lines`, clears both fetch counters, clears `stall_count`, and moves to STREAM.
  - `start`=1 with `num_lines`=0 moves to FINISH without any reads.
- **STREAM:**
  - `pop = (fifo_count != 0) && !all_fetched && (!m_valid || m_ready)`.
  - `fifo_rd_en = pop`, purely combinational from registered state and inputs.
- **On pop:**
  - `m_data` ← `fifo_data`, and `m_valid` ← 1.
  - `m_first` ← (`fetch_sample`==0).
  - `m_last` ← (`fetch_sample`==`LINE_LEN-1`).
- **Fetch counters:**
  - `fetch_sample` increments per pop and wraps to 0 after `LINE_LEN-1`.
  - On wrap, `fetch_line` increments.
  - `all_fetched` sets on the pop that takes the last sample of line `num_lines-1`.
- **Output register:**
  - When `m_valid && m_ready && !pop`, `m_valid` ← 0.
  - Data and flags hold while `m_valid && !m_ready`.
- **Stall counting:** `stall_count` +1 on every STREAM cycle with `!all_fetched && (!m_valid || m_ready) && fifo_count==0`. It saturates at 16'hFFFF.
- **Leaving STREAM:** the handshake (`m_valid && m_ready`) of the beat with `m_last`=1 while `all_fetched`=1 moves to FINISH.
- **FINISH:** lasts one cycle. `done`=1 and `busy`=0, then the block returns to IDLE.
- **Ignored input:** `start` during STREAM or FINISH has no effect.
- **Reset:** asynchronous. `fifo_rd_en`, `m_valid`, `m_first`, `m_last`, `busy`, `done` all go to 0; `m_data`, `stall_count`, and the counters go to 0; the state goes to IDLE. A reset mid-line abandons the line. FIFO contents are the FIFO's own concern.
- `stall_count` holds its value in IDLE, so it remains readable after `done`.

## Timing
- **Start:** `start` accepted at edge N gives STREAM and `busy`=1 from N+1. The earliest `fifo_rd_en` is in cycle N+1.
- **Latency:** a pop in cycle t gives `m_valid`=1 with that sample in cycle t+1.
- **Throughput:** 1 sample/clk when the FIFO is non-empty and `m_ready`=1.
- **Backpressure:** `m_ready`=0 blocks popping in the same cycle. There is no skid buffer and no sample loss.
- **Completion:** final handshake in cycle k gives FINISH in k+1 (`done`=1, `busy`=0, `m_valid`=0) and IDLE in k+2. A new `start` is accepted from k+2.
- **`num_lines`=0:** `start` at N gives `done` in N+1 and IDLE in N+2, with `busy` never asserted.
- **Total beats:** exactly `num_lines*LINE_LEN`. No pop occurs after `all_fetched`, even if the FIFO is full.

## Test plan
- **Streaming:** `LINE_LEN`=4, `num_lines`=2, FIFO preloaded with 1..8, `m_ready`=1.
  - 8 consecutive beats 1..8, the first 2 clk after `start`.
  - `m_first` on 1 and 5; `m_last` on 4 and 8.
  - `done` 1 clk after beat 8; `stall_count`=0.
- **Backpressure:** same stimulus with `m_ready` toggled 1,0,1,0.
  - Data order is unchanged and no duplicates appear.
  - `fifo_rd_en` is never high while `m_valid && !m_ready`.
- **Starvation:** FIFO empty for 5 clk mid-line, then refilled. `stall_count`=5 with the beat sequence intact.
- **Zero lines:** `num_lines`=0. `done` in the cycle after `start`, with zero `fifo_rd_en` and zero `m_valid` cycles.
- **Ignored start and overrun guard:** `start` pulsed again during STREAM, with the FIFO holding 12 samples for an 8-sample job. The second `start` is ignored and 4 samples remain in the FIFO after `done`.
- **Reset mid-line:** `reset` asserted after beat 3 of 8. All outputs are 0 in the same cycle. After a fresh `start`, `m_first` is set on the next beat.

Source files
------------

// File: rtl/echo_line_reader.sv
// echo_line_reader
//   Drains echo samples from a FIFO's combinational read port and re-frames
//   them into scan lines of LINE_LEN samples on a valid/ready stream.
//   A start pulse arms a capture of num_lines lines; busy/done report
//   progress and stall_count accumulates FIFO-starvation cycles.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   start, num_lines    arm pulse (sampled in IDLE) and line count
//   fifo_data/count     FIFO head sample and occupancy
//   fifo_rd_en          pop strobe toward the FIFO
//   m_data/valid/ready  output sample stream
//   m_first/m_last      beat is sample 0 / sample LINE_LEN-1 of a line
//   busy, done          status toward the sequencer
//   stall_count         saturating count of starved cycles
module echo_line_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int LINE_LEN   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           num_lines,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_count
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t        state, state_next;
  logic [15:0]   lines_q;
  logic [15:0]   fetch_line;
  logic [CW-1:0] fetch_sample;
  logic          all_fetched;
  logic          slot_free;
  logic          hs;
  logic          pop;
  logic          stall;
  logic          arm;

  always_comb begin
    // The output register can take a new sample when empty or draining now.
    slot_free  = !m_valid || m_ready;
    hs         = m_valid && m_ready;
    pop        = (state == STREAM) && (fifo_count != '0) && !all_fetched && slot_free;
    stall      = (state == STREAM) && !all_fetched && slot_free && (fifo_count == '0);
    arm        = (state == IDLE) && start && (num_lines != 16'd0);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_lines != 16'd0) ? STREAM : FINISH;
      STREAM:  if (hs && m_last && all_fetched) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rd_en = pop;
  assign busy       = (state == STREAM);
  assign done       = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lines_q      <= '0;
      fetch_line   <= '0;
      fetch_sample <= '0;
      all_fetched  <= 1'b0;
      stall_count  <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_first      <= 1'b0;
      m_last       <= 1'b0;
    end else begin
      state <= state_next;
      if (arm) begin
        lines_q      <= num_lines;
        fetch_line   <= '0;
        fetch_sample <= '0;
        all_fetched  <= 1'b0;
        stall_count  <= '0;
      end else begin
        if (pop) begin
          m_data  <= fifo_data;
          m_valid <= 1'b1;
          m_first <= (fetch_sample == '0);
          m_last  <= (fetch_sample == LAST_SAMPLE);
          if (fetch_sample == LAST_SAMPLE) begin
            fetch_sample <= '0;
            fetch_line   <= fetch_line + 16'd1;
            // Last sample of the last line: stop popping from here on.
            if (fetch_line == lines_q - 16'd1) all_fetched <= 1'b1;
          end else begin
            fetch_sample <= fetch_sample + 1'b1;
          end
        end else if (hs) begin
          m_valid <= 1'b0;
        end
        if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_echo_line_reader.sv
// tb_echo_line_reader
//   Self-checking bench for echo_line_reader (LINE_LEN=4, 16-deep FIFO model).
//   The FIFO is a bench-side array; expected beats are the FIFO contents in
//   push order, framed by beat index, with stall cycles counted from the
//   observable starvation rule.
module tb_echo_line_reader;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int L     = 4;
  localparam int DEPTH = 16;
  localparam int CNTW  = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   num_lines;
  logic [DW-1:0] fifo_data;
  logic [AW:0]   fifo_count;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_first;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [15:0]   stall_count;

  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int cyc = 0;
  int hs_total = 0, rden_total = 0, busy_total = 0, valid_total = 0, done_total = 0;
  int hs_base = 0, rden_base = 0, busy_base = 0, valid_base = 0;
  int job_base = 0, job_total = 0, start_cyc = 0, model_stall = 0;
  int done_cyc = -1, last_hs_cyc = -1, first_hs_cyc = -1;
  int n_cmp = 0, n_err = 0;

  assign fifo_count = CNTW'(wr_ptr - rd_ptr);
  assign fifo_data  = mem[rd_ptr % 1024];

  always #5 clk = ~clk;

  echo_line_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_LEN(L)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .fifo_data(fifo_data), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_first(m_first), .m_last(m_last), .busy(busy), .done(done),
    .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 1024] = v;
    wr_ptr++;
  endtask

  // One clock: observe at the falling edge, then let the FIFO pop after the rise.
  task automatic tick();
    int   idx;
    logic pop_now;
    @(negedge clk);
    pop_now = 1'b0;
    if (!reset) begin
      if (m_valid && m_ready) begin
        idx = hs_total - hs_base;
        check("beat_in_job", 64'(idx < job_total), 64'd1);
        if (idx < job_total)
          check("beat", {m_data, m_first, m_last},
                {mem[(job_base + idx) % 1024], (idx % L) == 0, (idx % L) == (L - 1)});
        if (idx == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_total++;
      end
      if (m_valid && !m_ready) check("no_pop_while_held", fifo_rd_en, 0);
      if (busy && fifo_count == 0 && (!m_valid || m_ready) && (rden_total - rden_base) < job_total)
        model_stall++;
      if (fifo_rd_en) begin
        rden_total++;
        pop_now = 1'b1;
      end
      busy_total  += int'(busy);
      valid_total += int'(m_valid);
      if (done) begin
        done_total++;
        done_cyc = cyc;
        check("finish_outputs", {busy, m_valid}, 0);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now) rd_ptr++;
  endtask

  task automatic do_start(input logic [15:0] nl);
    start       = 1'b1;
    num_lines   = nl;
    job_base    = rd_ptr;
    job_total   = int'(nl) * L;
    hs_base     = hs_total;
    rden_base   = rden_total;
    busy_base   = busy_total;
    valid_base  = valid_total;
    start_cyc   = cyc;
    first_hs_cyc = -1;
    if (nl != 16'd0) model_stall = 0;
    tick();
    start     = 1'b0;
    num_lines = 16'($urandom);
  endtask

  task automatic run_to_done(input int budget, input int ready_mode, input bit rand_push);
    int d0 = done_total;
    int i  = 0;
    while (done_total == d0 && i < budget) begin
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (i % 2) == 0;
        default: m_ready = ($urandom % 3) != 0;
      endcase
      if (rand_push && (wr_ptr - rd_ptr) < DEPTH && ($urandom % 4) != 0) push(16'($urandom));
      tick();
      i++;
    end
    check("done_within_budget", 64'(done_total != d0), 64'd1);
  endtask

  task automatic check_job();
    check("beats", hs_total - hs_base, job_total);
    check("pops", rden_total - rden_base, job_total);
    if (job_total != 0) check("done_after_last", done_cyc, last_hs_cyc + 1);
    check("stall_count", stall_count, model_stall);
    tick();
    check("idle_after", {busy, done, m_valid}, 0);
    check("stall_hold", stall_count, model_stall);
  endtask

  initial begin
    int i;
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    reset = 1'b1; start = 1'b0; num_lines = '0; m_ready = 1'b0;
    @(posedge clk); #1;
    check("reset_ctrl", {fifo_rd_en, m_valid, m_first, m_last, busy, done}, 0);
    check("reset_data", m_data, 0);
    check("reset_stall", stall_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // Streaming, full rate
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 8; v++) push(16'(v));
    m_ready = 1'b1;
    do_start(16'd2);
    run_to_done(40, 0, 1'b0);
    check("first_beat_latency", first_hs_cyc, start_cyc + 2);
    check("last_beat_cycle", last_hs_cyc, start_cyc + 9);
    check("busy_cycles", busy_total - busy_base, 9);
    check("stream_no_stall", stall_count, 0);
    check_job();

    // Backpressure, m_ready alternating
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 8; v++) push(16'(v));
    do_start(16'd2);
    run_to_done(60, 1, 1'b0);
    check_job();

    // Starvation for five cycles mid-line
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 3; v++) push(16'(v));
    m_ready = 1'b1;
    do_start(16'd2);
    i = 0;
    while (wr_ptr != rd_ptr && i < 20) begin tick(); i++; end
    check("drained", wr_ptr - rd_ptr, 0);
    repeat (5) tick();
    for (int v = 4; v <= 8; v++) push(16'(v));
    run_to_done(40, 0, 1'b0);
    check("starve_stall", stall_count, 5);
    check_job();

    // Zero lines: completes without touching the FIFO
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 3; v++) push(16'(v + 100));
    do_start(16'd0);
    run_to_done(5, 0, 1'b0);
    check("zero_done_cycle", done_cyc, start_cyc + 1);
    check("zero_valid", valid_total - valid_base, 0);
    check("zero_busy", busy_total - busy_base, 0);
    check_job();
    check("zero_fifo_untouched", wr_ptr - rd_ptr, 3);

    // Ignored start and overrun guard
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 12; v++) push(16'(v));
    do_start(16'd2);
    tick();
    tick();
    start = 1'b1; num_lines = 16'd5;
    tick();
    start = 1'b0;
    run_to_done(60, 0, 1'b0);
    check_job();
    check("overrun_left", wr_ptr - rd_ptr, 4);
    check("overrun_head", fifo_data, 9);

    // Reset mid-line, then restart
    wr_ptr = rd_ptr;
    for (int v = 1; v <= 8; v++) push(16'(v));
    m_ready = 1'b1;
    do_start(16'd2);
    i = 0;
    while ((hs_total - hs_base) < 3 && i < 20) begin tick(); i++; end
    check("three_beats", hs_total - hs_base, 3);
    reset = 1'b1;
    #1;
    check("reset_mid_ctrl", {fifo_rd_en, m_valid, m_first, m_last, busy, done}, 0);
    check("reset_mid_data", m_data, 0);
    check("reset_mid_stall", stall_count, 0);
    tick();
    reset = 1'b0;
    tick();
    do_start(16'd1);
    run_to_done(30, 0, 1'b0);
    check("restart_first_latency", first_hs_cyc, start_cyc + 2);
    check_job();

    // Randomized jobs: random backpressure and FIFO refill
    for (int j = 0; j < 4; j++) begin
      wr_ptr = rd_ptr;
      for (int k = 0; k < int'($urandom % 6); k++) push(16'($urandom));
      do_start(16'(1 + $urandom % 3));
      run_to_done(800, 2, 1'b1);
      check_job();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
